// File: rtl/chaos_key_xor.sv
// chaos_key_xor: turns a stream of sawtooth-map float32 samples into 8-bit
// keys and XORs each key with one pixel. The same block encrypts and
// decrypts. Keys go through a one-cycle quantize stage into a small FIFO.
// The FIFO head pairs with the next accepted pixel. The result waits in a
// single output register until downstream takes it.
module chaos_key_xor #(
  parameter int PRECISION = 32,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 chaos_valid,
  input  logic [PRECISION-1:0] chaos_value,
  output logic                 chaos_ready,
  input  logic                 pix_valid,
  input  logic [7:0]           pix_in,
  output logic                 pix_ready,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  input  logic                 out_ready,
  output logic                 err_sticky,
  output logic [31:0]          byte_cnt
);

  localparam int PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CntW = $clog2(DEPTH + 1);

  // Quantize stage
  logic             qValid_q, qValid_d;
  logic [7:0]       qKey_q, qKey_d;

  // Key FIFO
  logic [7:0]       mem_q [DEPTH];
  logic [PtrW-1:0]  rdPtr_q, rdPtr_d;
  logic [PtrW-1:0]  wrPtr_q, wrPtr_d;
  logic [CntW-1:0]  count_q, count_d;

  // Output register and status
  logic             outValid_q, outValid_d;
  logic [7:0]       outData_q, outData_d;
  logic             errSticky_q, errSticky_d;
  logic [31:0]      byteCnt_q, byteCnt_d;

  // Quantizer and handshake signals
  logic [7:0]       expField;
  logic [31:0]      mantExt;
  logic [31:0]      fixVal;
  logic [7:0]       chaosKey;
  logic             chaosOverRange;
  logic [CntW:0]    occupancy;
  logic             chaosFire;
  logic             pixFire;
  logic             outFire;

  // Scale the magnitude of the float by 2^32 and fold the 32-bit result
  // down to one key byte. The sign bit is ignored. Values of 1.0 or more,
  // including Inf and NaN, are flagged out of range.
  always_comb begin
    expField       = chaos_value[30:23];
    mantExt        = {8'h00, 1'b1, chaos_value[22:0]};
    fixVal         = '0;
    if (expField >= 8'd95 && expField <= 8'd117) begin
      fixVal = mantExt >> (8'd118 - expField);
    end else if (expField == 8'd118) begin
      fixVal = mantExt;
    end else if (expField >= 8'd119 && expField <= 8'd126) begin
      fixVal = mantExt << (expField - 8'd118);
    end
    chaosKey       = fixVal[31:24] ^ fixVal[23:16] ^ fixVal[15:8] ^ fixVal[7:0];
    chaosOverRange = (expField >= 8'd127);
  end

  // Compute the ready signals and handshakes. A key sitting in the quantize
  // stage counts as occupied space. A pop in the same cycle does not count
  // as freed space, which keeps chaos_ready off the pixel path.
  always_comb begin
    occupancy   = {1'b0, count_q} + (CntW + 1)'(qValid_q);
    chaos_ready = reset_n && (occupancy < (CntW + 1)'(DEPTH));
    pix_ready   = reset_n && (count_q != '0) && (!outValid_q || out_ready);
    chaosFire   = chaos_valid && chaos_ready;
    pixFire     = pix_valid && pix_ready;
    outFire     = outValid_q && out_ready;
  end

  // Compute next state for the quantize stage, FIFO pointers, output
  // register and counters.
  always_comb begin
    qValid_d    = chaosFire && !chaosOverRange;
    qKey_d      = chaosFire ? chaosKey : qKey_q;
    wrPtr_d     = qValid_q ? wrPtr_q + 1'b1 : wrPtr_q;
    rdPtr_d     = pixFire ? rdPtr_q + 1'b1 : rdPtr_q;
    count_d     = count_q + CntW'(qValid_q) - CntW'(pixFire);
    errSticky_d = errSticky_q || (chaosFire && chaosOverRange);
    outValid_d  = outValid_q;
    outData_d   = outData_q;
    if (pixFire) begin
      outValid_d = 1'b1;
      outData_d  = pix_in ^ mem_q[rdPtr_q];
    end else if (outFire) begin
      outValid_d = 1'b0;
    end
    byteCnt_d   = byteCnt_q + 32'(outFire);
  end

  // Write the key leaving the quantize stage into the FIFO storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (qValid_q) begin
      mem_q[wrPtr_q] <= qKey_q;
    end
  end

  // Update the control and datapath registers. Reset drops any in-flight key
  // or output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      qValid_q    <= 1'b0;
      qKey_q      <= 8'h00;
      rdPtr_q     <= '0;
      wrPtr_q     <= '0;
      count_q     <= '0;
      outValid_q  <= 1'b0;
      outData_q   <= 8'h00;
      errSticky_q <= 1'b0;
      byteCnt_q   <= 32'h0;
    end else begin
      qValid_q    <= qValid_d;
      qKey_q      <= qKey_d;
      rdPtr_q     <= rdPtr_d;
      wrPtr_q     <= wrPtr_d;
      count_q     <= count_d;
      outValid_q  <= outValid_d;
      outData_q   <= outData_d;
      errSticky_q <= errSticky_d;
      byteCnt_q   <= byteCnt_d;
    end
  end

  assign out_valid  = outValid_q;
  assign out_data   = outData_q;
  assign err_sticky = errSticky_q;
  assign byte_cnt   = byteCnt_q;

endmodule

// File: tb/tb_chaos_key_xor.sv
// Testbench for chaos_key_xor. A reference model sits beside a scoreboard
// queue of expected output bytes. Directed scenarios run first, then
// randomized traffic.
module tb_chaos_key_xor;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        chaos_valid;
  logic [31:0] chaos_value;
  logic        chaos_ready;
  logic        pix_valid;
  logic [7:0]  pix_in;
  logic        pix_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        err_sticky;
  logic [31:0] byte_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [7:0]  keyQ[$];
  logic [7:0]  expQ[$];
  logic        pendingValid = 1'b0;
  logic [7:0]  pendingKey = 8'h00;
  logic        expErr = 1'b0;
  logic [31:0] expBytes = 32'h0;
  logic [7:0]  mKey;
  logic        mOvr;
  logic [7:0]  mHead;

  chaos_key_xor #(.PRECISION(32), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .chaos_valid(chaos_valid),
    .chaos_value(chaos_value),
    .chaos_ready(chaos_ready),
    .pix_valid(pix_valid),
    .pix_in(pix_in),
    .pix_ready(pix_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .err_sticky(err_sticky),
    .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  // Reference key: floor(|value| * 2^32) computed in real arithmetic, then
  // folded into a byte by XOR of its four bytes.
  function automatic logic [7:0] refKey(input logic [31:0] word, output logic overRange);
    int          e;
    real         m;
    real         scaled;
    longint      f;
    logic [31:0] fw;
    e = int'(word[30:23]);
    m = real'({1'b1, word[22:0]});
    overRange = (e >= 127);
    if (overRange) return 8'h00;
    scaled = $floor(m * (2.0 ** (e - 150)) * 4294967296.0);
    f = longint'(scaled);
    fw = f[31:0];
    return fw[31:24] ^ fw[23:16] ^ fw[15:8] ^ fw[7:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic cv, input logic [31:0] cval, input logic pv,
                               input logic [7:0] pin, input logic ordy);
    chaos_valid = cv;
    chaos_value = cval;
    pix_valid   = pv;
    pix_in      = pin;
    out_ready   = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 8'h00, 1'b0);
    reset_n = 1'b1;
  endtask

  // Monitor: sample away from the rising edge and compare the DUT against
  // the model. Then advance the model by the handshakes about to happen.
  always @(negedge clk) begin
    if (!reset_n) begin
      keyQ.delete();
      expQ.delete();
      pendingValid = 1'b0;
      expErr = 1'b0;
      expBytes = 32'h0;
      checkOutput("rst_chaos_ready", 32'(chaos_ready), 32'(0));
      checkOutput("rst_pix_ready", 32'(pix_ready), 32'(0));
      checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
      checkOutput("rst_out_data", 32'(out_data), 32'(0));
      checkOutput("rst_err", 32'(err_sticky), 32'(0));
      checkOutput("rst_byte_cnt", byte_cnt, 32'h0);
    end else begin
      checkOutput("chaos_ready", 32'(chaos_ready), 32'((keyQ.size() + int'(pendingValid)) < DEPTH));
      checkOutput("pix_ready", 32'(pix_ready),
                  32'((keyQ.size() > 0) && ((expQ.size() == 0) || out_ready)));
      checkOutput("out_valid", 32'(out_valid), 32'(expQ.size() > 0));
      checkOutput("err_sticky", 32'(err_sticky), 32'(expErr));
      checkOutput("byte_cnt", byte_cnt, expBytes);
      if (out_valid && expQ.size() > 0) begin
        checkOutput("out_data", 32'(out_data), 32'(expQ[0]));
        if (out_ready) begin
          void'(expQ.pop_front());
          expBytes = expBytes + 32'h1;
        end
      end
      if (pix_valid && pix_ready && keyQ.size() > 0) begin
        mHead = keyQ.pop_front();
        expQ.push_back(pix_in ^ mHead);
      end
      if (pendingValid) keyQ.push_back(pendingKey);
      pendingValid = 1'b0;
      if (chaos_valid && chaos_ready) begin
        mKey = refKey(chaos_value, mOvr);
        if (mOvr) begin
          expErr = 1'b1;
        end else begin
          pendingKey = mKey;
          pendingValid = 1'b1;
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Stimulus: directed scenarios first, then random traffic.
  initial begin
    logic [31:0] rv;
    reset_n     = 1'b0;
    chaos_valid = 1'b0;
    chaos_value = 32'h0;
    pix_valid   = 1'b0;
    pix_in      = 8'h00;
    out_ready   = 1'b0;
    @(posedge clk);
    #1;
    doReset();

    // 0.5 then pixel 0x12 gives 0x92.
    applyStimulus(1'b1, 32'h3F000000, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 8'h12, 1'b1);
    checkOutput("d038_valid", 32'(out_valid), 32'(1));
    checkOutput("d038_data", 32'(out_data), 32'h92);
    applyStimulus(1'b0, 32'h0, 1'b0, 8'h00, 1'b1);

    // 0.05 then pixel 0x00 gives 0xDC.
    applyStimulus(1'b1, 32'h3D4CCCCD, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 8'h00, 1'b1);
    checkOutput("d039_data", 32'(out_data), 32'hDC);
    applyStimulus(1'b0, 32'h0, 1'b0, 8'h00, 1'b1);

    // 1.75 is out of range: error flag set, no key, pixel never accepted.
    applyStimulus(1'b1, 32'h3FE00000, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 8'h55, 1'b1);
    checkOutput("d040_err", 32'(err_sticky), 32'(1));
    checkOutput("d040_pix_ready", 32'(pix_ready), 32'(0));
    applyStimulus(1'b0, 32'h0, 1'b0, 8'h00, 1'b1);

    // Fill the FIFO with a stalled output, then check the pixel back-pressure.
    doReset();
    applyStimulus(1'b1, 32'h3F000000, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 32'h3F400000, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 32'h3D4CCCCD, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 32'h3E800000, 1'b0, 8'h00, 1'b0);
    checkOutput("d041_full", 32'(chaos_ready), 32'(0));
    applyStimulus(1'b1, 32'h3F000000, 1'b0, 8'h00, 1'b0);
    checkOutput("d041_full2", 32'(chaos_ready), 32'(0));
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 8'hA0, 1'b0);
    checkOutput("d041_hold_valid", 32'(out_valid), 32'(1));
    checkOutput("d041_hold_data", 32'(out_data), 32'h20);
    checkOutput("d041_hold_pix", 32'(pix_ready), 32'(0));
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b1, 8'hA0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b0, 8'h00, 1'b1);

    // Streaming 0.5 / 0.75 gives 0x80 and 0xC0 back to back.
    doReset();
    applyStimulus(1'b1, 32'h3F000000, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b1, 32'h3F400000, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 8'h00, 1'b1);
    checkOutput("d042_first", 32'(out_data), 32'h80);
    applyStimulus(1'b0, 32'h0, 1'b1, 8'h00, 1'b1);
    checkOutput("d042_second", 32'(out_data), 32'hC0);
    checkOutput("d042_second_valid", 32'(out_valid), 32'(1));
    applyStimulus(1'b0, 32'h0, 1'b0, 8'h00, 1'b1);
    checkOutput("d042_byte_cnt", byte_cnt, 32'd2);

    // Reset mid-operation with three keys queued and an output pending.
    doReset();
    applyStimulus(1'b1, 32'h3F000000, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 32'h3F400000, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 32'h3D4CCCCD, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 32'h3E800000, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 8'h33, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 8'h00, 1'b0);
    checkOutput("d043_pre_valid", 32'(out_valid), 32'(1));
    reset_n = 1'b0;
    #1;
    checkOutput("d043_rst_valid", 32'(out_valid), 32'(0));
    checkOutput("d043_rst_data", 32'(out_data), 32'(0));
    checkOutput("d043_rst_chaos_ready", 32'(chaos_ready), 32'(0));
    applyStimulus(1'b0, 32'h0, 1'b0, 8'h00, 1'b0);
    reset_n = 1'b1;
    #1;
    checkOutput("d043_release_ready", 32'(chaos_ready), 32'(1));
    checkOutput("d043_release_pix", 32'(pix_ready), 32'(0));
    @(posedge clk);
    #1;

    // Randomized traffic with a mid-run reset.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) doReset();
      if ($urandom_range(0, 9) == 0) rv = $urandom;
      else rv = {1'($urandom_range(0, 1)), 8'($urandom_range(92, 126)), 23'($urandom)};
      applyStimulus(1'($urandom_range(0, 1)), rv, ($urandom_range(0, 9) < 7),
                    8'($urandom), ($urandom_range(0, 9) < 7));
    end

    // Drain the outstanding output within a bounded number of cycles.
    for (int n = 0; n < 20 && expQ.size() != 0; n++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 8'h00, 1'b1);
    end
    checkOutput("drain_empty", 32'(expQ.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
